frame_bank_scheduler: RTL and testbench
=======================================

Name: frame_bank_scheduler

Overview:
- Triple-buffer bank scheduler for the SDRAM frame store shared by the camera writer (WR1) and two display readers: VGA (RD1) and TFT (RD2).
- Allocates one of three fixed SDRAM banks to the camera for each frame and publishes the last completed bank to each reader at that reader's own frame start.
- Emits per-port base addresses and one-cycle load strobes to the SDRAM multi-port controller, plus a write gate for the camera FIFO. Prevents tearing without locking the camera frame rate to either display.

Parameters:
- ADDR_W, 24, width of SDRAM word address outputs.
- BASE_ADDR, 0, word address of bank 0.
- BANK_WORDS, 76800, words per bank (320x240); bank n base = BASE_ADDR + n*BANK_WORDS.
- CNT_W, 8, width of dropped-frame counter.

Ports:
- clk  in  1  scheduler clock; all inputs are synchronous single-cycle pulses in this domain.
- rst  in  1  asynchronous reset, active-high.
- cam_frame_start  in  1  pulse at camera frame start (VSYNC end).
- cam_frame_done  in  1  pulse after last camera pixel has been written.
- rd1_frame_start  in  1  VGA reader frame-start pulse.
- rd2_frame_start  in  1  TFT reader frame-start pulse.
- wr_base  out  ADDR_W  base address for WR1.
- wr_load  out  1  one-cycle load strobe for WR1 address.
- wr_en  out  1  camera write gate (drives WR1).
- rd1_base  out  ADDR_W  base address for RD1.
- rd1_load  out  1  one-cycle load strobe for RD1.
- rd2_base  out  ADDR_W  base address for RD2.
- rd2_load  out  1  one-cycle load strobe for RD2.
- latest_valid  out  1  at least one frame has been committed.
- dropped_frames  out  CNT_W  saturating count of camera frames not stored.

Behaviour:
- Reset values: all bank indices 0; latest_valid 0; rd1_valid and rd2_valid (internal) 0; wr_en 0; all load strobes 0; dropped_frames 0; writer FSM in IDLE; all base outputs = BASE_ADDR.
- Bank index is 2 bits; only values 0..2 are legal. Base outputs are registered: bank*BANK_WORDS + BASE_ADDR, truncated to ADDR_W.
- Free bank: the lowest index n in 0..2 that is not any of:
  - rd1_bank, if rd1_valid
  - rd2_bank, if rd2_valid
  - latest_bank, if latest_valid
- Writer FSM states: IDLE, WRITING, COMMIT, SKIP.
  - IDLE + cam_frame_start, free bank exists: wr_bank <= free bank; wr_base updates; wr_load = 1 for exactly the next cycle; wr_en = 1 from that same cycle; go to WRITING.
  - IDLE + cam_frame_start, no free bank: go to SKIP; dropped_frames += 1 (saturates at all-ones); wr_en stays 0.
  - IDLE + cam_frame_done: ignored.
  - WRITING + cam_frame_done: wr_en <= 0; go to COMMIT.
  - WRITING + cam_frame_start (missing done): abort. Frame is discarded, latest unchanged, dropped_frames += 1, and a new allocation is made in the same cycle using IDLE rules.
  - COMMIT, exactly 1 cycle: latest_bank <= wr_bank; latest_valid <= 1; go to IDLE.
  - SKIP + cam_frame_done: go to IDLE. SKIP + cam_frame_start: count another drop and re-evaluate allocation as in IDLE.
- Readers (independent, identical logic):
  - On rdN_frame_start with latest_valid = 1: rdN_bank <= latest_bank; rdN_valid <= 1; rdN_base updates; rdN_load = 1 for exactly the next cycle.
  - With latest_valid = 0: no load, rdN_valid stays 0.
  - A reader keeps its bank until its next frame start, even if the same bank is re-published.
- Simultaneous events:
  - COMMIT and rdN_frame_start in the same cycle: the reader receives the pre-commit latest_bank. The new frame is taken at the next reader start.
  - rd1 and rd2 starting in the same cycle: both receive the same bank.
  - Reader start in the same cycle as allocation: allocation uses the pre-update reader banks. Exclusion of latest_bank guarantees the two can never collide.
- Invariant: wr_bank while wr_en = 1 never equals any valid reader bank, nor latest_bank.
- Latency: input pulse to load strobe and base update = 1 cycle.
- Asynchronous reset mid-frame returns immediately to reset values. wr_en drops asynchronously.

Test Plan:
- Reset, then cam_frame_start -> wr_base = 0, wr_load high 1 cycle, wr_en = 1. cam_frame_done -> wr_en = 0, latest_valid = 1 two cycles later, latest bank 0.
- rd1_frame_start before any commit -> no rd1_load, rd1_base = BASE_ADDR. After bank-0 commit, rd1_frame_start -> rd1_load pulse, rd1_base = 0.
- rd1 holds 0, latest = 1, rd2 holds 1, next camera frame -> allocated bank 2, wr_base = 153600.
- rd1 = 0, rd2 = 1, latest = 2, cam_frame_start -> SKIP, wr_en stays 0, dropped_frames = 1. Repeated 300 times -> dropped_frames saturates at 255.
- COMMIT cycle coincides with rd2_frame_start -> rd2 receives the previous latest bank. Next rd2 start receives the new bank.
- cam_frame_start during WRITING (no done) -> dropped_frames += 1, new wr_load, latest_bank unchanged. Assert rst mid-WRITING -> wr_en = 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/frame_bank_scheduler_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | frame_bank_scheduler_if - frame event pulses in, bank addresses/strobes out|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 8
);
  logic              cam_frame_start;
  logic              cam_frame_done;
  logic              rd1_frame_start;
  logic              rd2_frame_start;
  logic [ADDR_W-1:0] wr_base;
  logic              wr_load;
  logic              wr_en;
  logic [ADDR_W-1:0] rd1_base;
  logic              rd1_load;
  logic [ADDR_W-1:0] rd2_base;
  logic              rd2_load;
  logic              latest_valid;
  logic [CNT_W-1:0]  dropped_frames;

  modport master (
    output cam_frame_start, cam_frame_done, rd1_frame_start, rd2_frame_start,
    input  wr_base, wr_load, wr_en, rd1_base, rd1_load, rd2_base, rd2_load,
           latest_valid, dropped_frames
  );

  modport slave (
    input  cam_frame_start, cam_frame_done, rd1_frame_start, rd2_frame_start,
    output wr_base, wr_load, wr_en, rd1_base, rd1_load, rd2_base, rd2_load,
           latest_valid, dropped_frames
  );
endinterface
`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | frame_bank_scheduler - triple-buffer bank allocation for camera/VGA/TFT    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module frame_bank_scheduler #(
  parameter int ADDR_W     = 24,
  parameter int BASE_ADDR  = 0,
  parameter int BANK_WORDS = 76800,
  parameter int CNT_W      = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  frame_bank_scheduler_if.slave  bus
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_writing = 2'd1;
  localparam logic [1:0] c_commit  = 2'd2;
  localparam logic [1:0] c_skip    = 2'd3;

  localparam logic [ADDR_W-1:0] c_base0   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_base1   = ADDR_W'(BASE_ADDR + BANK_WORDS);
  localparam logic [ADDR_W-1:0] c_base2   = ADDR_W'(BASE_ADDR + 2 * BANK_WORDS);
  localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        wr_bank_q, wr_bank_d;
  logic [1:0]        latest_bank_q, latest_bank_d;
  logic [1:0]        rd1_bank_q, rd1_bank_d;
  logic [1:0]        rd2_bank_q, rd2_bank_d;
  logic              latest_valid_q, latest_valid_d;
  logic              rd1_valid_q, rd1_valid_d;
  logic              rd2_valid_q, rd2_valid_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_load_q, wr_load_d;
  logic              rd1_load_q, rd1_load_d;
  logic              rd2_load_q, rd2_load_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd1_base_q, rd1_base_d;
  logic [ADDR_W-1:0] rd2_base_q, rd2_base_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [2:0]        busy;
  logic              free_ok;
  logic [1:0]        free_bank;
  logic              alloc;
  logic              drop;

  function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
    case (b)
      2'd1:    bank_base = c_base1;
      2'd2:    bank_base = c_base2;
      default: bank_base = c_base0;
    endcase
  endfunction

  // During COMMIT the bank being published is excluded as well as the old
  // latest, since a reader starting this cycle may still grab the old one.
  always_comb begin
    busy = 3'b000;
    for (int n = 0; n < 3; n++) begin
      busy[n] = (rd1_valid_q && rd1_bank_q == 2'(n)) ||
                (rd2_valid_q && rd2_bank_q == 2'(n)) ||
                (latest_valid_q && latest_bank_q == 2'(n)) ||
                (state_q == c_commit && wr_bank_q == 2'(n));
    end
    free_ok   = 1'b1;
    free_bank = 2'd0;
    if (!busy[0])      free_bank = 2'd0;
    else if (!busy[1]) free_bank = 2'd1;
    else if (!busy[2]) free_bank = 2'd2;
    else               free_ok   = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_idle;
    else     state_q <= state_d;
  end

  // A start in any state is treated as a fresh allocation attempt; an aborted
  // frame and a frame with no free bank each count as one drop.
  always_comb begin
    state_d = state_q;
    alloc   = 1'b0;
    drop    = 1'b0;
    if (bus.cam_frame_start) begin
      drop  = (state_q == c_writing) || !free_ok;
      alloc = free_ok;
      state_d = free_ok ? c_writing : c_skip;
    end else begin
      case (state_q)
        c_writing: if (bus.cam_frame_done) state_d = c_commit;
        c_commit:  state_d = c_idle;
        c_skip:    if (bus.cam_frame_done) state_d = c_idle;
        default:   state_d = c_idle;
      endcase
    end
  end

  always_comb begin
    wr_bank_d      = alloc ? free_bank : wr_bank_q;
    wr_base_d      = alloc ? bank_base(free_bank) : wr_base_q;
    wr_load_d      = alloc;
    wr_en_d        = (state_d == c_writing);
    latest_bank_d  = latest_bank_q;
    latest_valid_d = latest_valid_q;
    if (state_q == c_commit) begin
      latest_bank_d  = wr_bank_q;
      latest_valid_d = 1'b1;
    end
    drop_cnt_d = (drop && drop_cnt_q != c_cnt_max) ? drop_cnt_q + 1'b1 : drop_cnt_q;

    rd1_bank_d  = rd1_bank_q;
    rd1_valid_d = rd1_valid_q;
    rd1_base_d  = rd1_base_q;
    rd1_load_d  = 1'b0;
    if (bus.rd1_frame_start && latest_valid_q) begin
      rd1_bank_d  = latest_bank_q;
      rd1_valid_d = 1'b1;
      rd1_base_d  = bank_base(latest_bank_q);
      rd1_load_d  = 1'b1;
    end

    rd2_bank_d  = rd2_bank_q;
    rd2_valid_d = rd2_valid_q;
    rd2_base_d  = rd2_base_q;
    rd2_load_d  = 1'b0;
    if (bus.rd2_frame_start && latest_valid_q) begin
      rd2_bank_d  = latest_bank_q;
      rd2_valid_d = 1'b1;
      rd2_base_d  = bank_base(latest_bank_q);
      rd2_load_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q      <= 2'd0;
      latest_bank_q  <= 2'd0;
      rd1_bank_q     <= 2'd0;
      rd2_bank_q     <= 2'd0;
      latest_valid_q <= 1'b0;
      rd1_valid_q    <= 1'b0;
      rd2_valid_q    <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_load_q      <= 1'b0;
      rd1_load_q     <= 1'b0;
      rd2_load_q     <= 1'b0;
      wr_base_q      <= c_base0;
      rd1_base_q     <= c_base0;
      rd2_base_q     <= c_base0;
      drop_cnt_q     <= '0;
    end else begin
      wr_bank_q      <= wr_bank_d;
      latest_bank_q  <= latest_bank_d;
      rd1_bank_q     <= rd1_bank_d;
      rd2_bank_q     <= rd2_bank_d;
      latest_valid_q <= latest_valid_d;
      rd1_valid_q    <= rd1_valid_d;
      rd2_valid_q    <= rd2_valid_d;
      wr_en_q        <= wr_en_d;
      wr_load_q      <= wr_load_d;
      rd1_load_q     <= rd1_load_d;
      rd2_load_q     <= rd2_load_d;
      wr_base_q      <= wr_base_d;
      rd1_base_q     <= rd1_base_d;
      rd2_base_q     <= rd2_base_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign bus.wr_base        = wr_base_q;
  assign bus.wr_load        = wr_load_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.rd1_base       = rd1_base_q;
  assign bus.rd1_load       = rd1_load_q;
  assign bus.rd2_base       = rd2_base_q;
  assign bus.rd2_load       = rd2_load_q;
  assign bus.latest_valid   = latest_valid_q;
  assign bus.dropped_frames = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_frame_bank_scheduler - vector table, corner sequences, random vs model  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_frame_bank_scheduler;

  localparam int ADDR_W     = 24;
  localparam int BASE_ADDR  = 0;
  localparam int BANK_WORDS = 76800;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_bank_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sif ();

  frame_bank_scheduler #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .BANK_WORDS(BANK_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: banks as integers, -1 meaning "nothing held"
  int m_mode;      // 0 idle, 1 writing, 2 skipping
  bit m_commit;    // a finished frame is published on the next step
  int m_wr_bank, m_latest, m_rd1, m_rd2, m_drops;
  bit e_wl, e_r1l, e_r2l;

  function automatic longint base_of(input int b);
    longint v;
    v = longint'(BASE_ADDR) + longint'(b < 0 ? 0 : b) * BANK_WORDS;
    return v & ((64'd1 << ADDR_W) - 1);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_commit = 0; m_wr_bank = 0;
    m_latest = -1; m_rd1 = -1; m_rd2 = -1; m_drops = 0;
    e_wl = 0; e_r1l = 0; e_r2l = 0;
  endtask

  task automatic model_step(input bit cs, input bit cd, input bit r1, input bit r2);
    bit busy[3];
    int free;
    bit abort;
    busy = '{default: 1'b0};
    if (m_rd1 >= 0) busy[m_rd1] = 1'b1;
    if (m_rd2 >= 0) busy[m_rd2] = 1'b1;
    if (m_latest >= 0) busy[m_latest] = 1'b1;
    if (m_commit) busy[m_wr_bank] = 1'b1;
    free = -1;
    for (int n = 2; n >= 0; n--) if (!busy[n]) free = n;
    e_wl = 0; e_r1l = 0; e_r2l = 0;
    if (r1 && m_latest >= 0) begin m_rd1 = m_latest; e_r1l = 1; end
    if (r2 && m_latest >= 0) begin m_rd2 = m_latest; e_r2l = 1; end
    if (m_commit) begin m_latest = m_wr_bank; m_commit = 0; end
    abort = cs && (m_mode == 1);
    if (cs) begin
      if ((abort || free < 0) && m_drops < CNT_MAX) m_drops++;
      if (free >= 0) begin m_wr_bank = free; m_mode = 1; e_wl = 1; end
      else m_mode = 2;
    end else if (cd) begin
      if (m_mode == 1) begin m_mode = 0; m_commit = 1; end
      else if (m_mode == 2) m_mode = 0;
    end
  endtask

  task automatic check_model();
    chk("m_wr_load",  sif.wr_load,        e_wl);
    chk("m_wr_en",    sif.wr_en,          m_mode == 1);
    chk("m_wr_base",  sif.wr_base,        base_of(m_wr_bank));
    chk("m_rd1_load", sif.rd1_load,       e_r1l);
    chk("m_rd1_base", sif.rd1_base,       base_of(m_rd1));
    chk("m_rd2_load", sif.rd2_load,       e_r2l);
    chk("m_rd2_base", sif.rd2_base,       base_of(m_rd2));
    chk("m_latest_v", sif.latest_valid,   m_latest >= 0);
    chk("m_dropped",  sif.dropped_frames, m_drops);
  endtask

  task automatic step(input bit cs, input bit cd, input bit r1, input bit r2);
    sif.cam_frame_start = cs;
    sif.cam_frame_done  = cd;
    sif.rd1_frame_start = r1;
    sif.rd2_frame_start = r2;
    @(posedge clk);
    #1;
    sif.cam_frame_start = 1'b0;
    sif.cam_frame_done  = 1'b0;
    sif.rd1_frame_start = 1'b0;
    sif.rd2_frame_start = 1'b0;
    model_step(cs, cd, r1, r2);
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"},   sif.wr_en,          0);
    chk({tag, "_wr_load"}, sif.wr_load,        0);
    chk({tag, "_wr_base"}, sif.wr_base,        BASE_ADDR);
    chk({tag, "_rd1_ld"},  sif.rd1_load,       0);
    chk({tag, "_rd1_base"},sif.rd1_base,       BASE_ADDR);
    chk({tag, "_rd2_ld"},  sif.rd2_load,       0);
    chk({tag, "_rd2_base"},sif.rd2_base,       BASE_ADDR);
    chk({tag, "_latest_v"},sif.latest_valid,   0);
    chk({tag, "_dropped"}, sif.dropped_frames, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit cs, cd, r1, r2;
    bit wl, en;
    int wrb;
    bit r1l;
    int r1b;
    bit r2l;
    int r2b;
    bit lv;
    int d;
  } vec_t;

  localparam int NV = 22;
  localparam int B1 = 76800;
  localparam int B2 = 153600;
  vec_t vecs[NV];

  initial begin
    //          cs cd r1 r2  wl en wrb  r1l r1b r2l r2b lv d
    vecs[0]  = '{0, 0, 1, 0,  0, 0, 0,   0, 0,  0, 0,  0, 0};
    vecs[1]  = '{1, 0, 0, 0,  1, 1, 0,   0, 0,  0, 0,  0, 0};
    vecs[2]  = '{0, 0, 0, 0,  0, 1, 0,   0, 0,  0, 0,  0, 0};
    vecs[3]  = '{0, 1, 0, 0,  0, 0, 0,   0, 0,  0, 0,  0, 0};
    vecs[4]  = '{0, 0, 0, 0,  0, 0, 0,   0, 0,  0, 0,  1, 0};
    vecs[5]  = '{0, 0, 1, 0,  0, 0, 0,   1, 0,  0, 0,  1, 0};
    vecs[6]  = '{1, 0, 0, 0,  1, 1, B1,  0, 0,  0, 0,  1, 0};
    vecs[7]  = '{0, 1, 0, 0,  0, 0, B1,  0, 0,  0, 0,  1, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 0, B1,  0, 0,  0, 0,  1, 0};
    vecs[9]  = '{0, 0, 0, 1,  0, 0, B1,  0, 0,  1, B1, 1, 0};
    vecs[10] = '{1, 0, 0, 0,  1, 1, B2,  0, 0,  0, B1, 1, 0};
    vecs[11] = '{0, 1, 0, 0,  0, 0, B2,  0, 0,  0, B1, 1, 0};
    vecs[12] = '{0, 0, 0, 1,  0, 0, B2,  0, 0,  1, B1, 1, 0};  // commit + rd2 start
    vecs[13] = '{1, 0, 0, 0,  0, 0, B2,  0, 0,  0, B1, 1, 1};  // all banks held
    vecs[14] = '{1, 0, 0, 0,  0, 0, B2,  0, 0,  0, B1, 1, 2};
    vecs[15] = '{0, 1, 0, 0,  0, 0, B2,  0, 0,  0, B1, 1, 2};
    vecs[16] = '{0, 0, 0, 1,  0, 0, B2,  0, 0,  1, B2, 1, 2};
    vecs[17] = '{1, 0, 0, 0,  1, 1, B1,  0, 0,  0, B2, 1, 2};
    vecs[18] = '{1, 0, 0, 0,  1, 1, B1,  0, 0,  0, B2, 1, 3};  // abort mid-frame
    vecs[19] = '{0, 1, 0, 0,  0, 0, B1,  0, 0,  0, B2, 1, 3};
    vecs[20] = '{0, 0, 0, 0,  0, 0, B1,  0, 0,  0, B2, 1, 3};
    vecs[21] = '{0, 0, 1, 0,  0, 0, B1,  1, B1, 0, B2, 1, 3};

    sif.cam_frame_start = 1'b0;
    sif.cam_frame_done  = 1'b0;
    sif.rd1_frame_start = 1'b0;
    sif.rd2_frame_start = 1'b0;
    model_reset();
    do_reset();
    check_reset_values("rst");

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].cs, vecs[i].cd, vecs[i].r1, vecs[i].r2);
      chk($sformatf("v%0d_wr_load", i),  sif.wr_load,        vecs[i].wl);
      chk($sformatf("v%0d_wr_en", i),    sif.wr_en,          vecs[i].en);
      chk($sformatf("v%0d_wr_base", i),  sif.wr_base,        vecs[i].wrb);
      chk($sformatf("v%0d_rd1_load", i), sif.rd1_load,       vecs[i].r1l);
      chk($sformatf("v%0d_rd1_base", i), sif.rd1_base,       vecs[i].r1b);
      chk($sformatf("v%0d_rd2_load", i), sif.rd2_load,       vecs[i].r2l);
      chk($sformatf("v%0d_rd2_base", i), sif.rd2_base,       vecs[i].r2b);
      chk($sformatf("v%0d_latest_v", i), sif.latest_valid,   vecs[i].lv);
      chk($sformatf("v%0d_dropped", i),  sif.dropped_frames, vecs[i].d);
    end

    // rd1=1, rd2=2: commit bank 0 so every bank is held, then flood starts
    step(1, 0, 0, 0);
    chk("fill_wr_base", sif.wr_base, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
    chk("sat_dropped", sif.dropped_frames, 255);
    chk("sat_wr_en", sif.wr_en, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("sat_rd1_base", sif.rd1_base, 0);

    // Start a frame, then hit reset between clock edges
    step(1, 0, 0, 0);
    chk("pre_rst_wr_en", sif.wr_en, 1);
    chk("pre_rst_wr_base", sif.wr_base, B1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_reset_values("post");

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
